// File: rtl/bp_me_wb_master_if.sv
// Bundle of the BedRock mem_fwd/mem_rev channels and the Wishbone B4 classic
// master port that bp_me_wb_master bridges between.
// Header layout (LSB first): msg_type[3:0], size[2:0], addr[paddr-1:0], payload.
interface bp_me_wb_master_if
  #(parameter int paddr_width_p   = 40
   ,parameter int data_width_p    = 64
   ,parameter int payload_width_p = 16
   );

  localparam int hdr_width_lp        = 4 + 3 + paddr_width_p + payload_width_p;
  localparam int wbone_addr_width_lp = paddr_width_p - $clog2(data_width_p/8);

  // BedRock forward channel
  logic [hdr_width_lp-1:0]        mem_fwd_header_i;
  logic [data_width_p-1:0]        mem_fwd_data_i;
  logic                           mem_fwd_v_i;
  logic                           mem_fwd_ready_and_o;
  logic                           mem_fwd_last_i;

  // BedRock reverse channel
  logic [hdr_width_lp-1:0]        mem_rev_header_o;
  logic [data_width_p-1:0]        mem_rev_data_o;
  logic                           mem_rev_v_o;
  logic                           mem_rev_ready_and_i;
  logic                           mem_rev_last_o;

  // Wishbone classic master
  logic [wbone_addr_width_lp-1:0] adr_o;
  logic [data_width_p-1:0]        dat_o;
  logic                           cyc_o;
  logic                           stb_o;
  logic [data_width_p/8-1:0]      sel_o;
  logic                           we_o;
  logic [data_width_p-1:0]        dat_i;
  logic                           ack_i;

  // Bridge side
  modport master
    (input  mem_fwd_header_i, mem_fwd_data_i, mem_fwd_v_i, mem_fwd_last_i
           ,mem_rev_ready_and_i, dat_i, ack_i
    ,output mem_fwd_ready_and_o, mem_rev_header_o, mem_rev_data_o, mem_rev_v_o
           ,mem_rev_last_o, adr_o, dat_o, cyc_o, stb_o, sel_o, we_o
    );

  // Environment side (BedRock requester plus Wishbone slave)
  modport slave
    (output mem_fwd_header_i, mem_fwd_data_i, mem_fwd_v_i, mem_fwd_last_i
           ,mem_rev_ready_and_i, dat_i, ack_i
    ,input  mem_fwd_ready_and_o, mem_rev_header_o, mem_rev_data_o, mem_rev_v_o
           ,mem_rev_last_o, adr_o, dat_o, cyc_o, stb_o, sel_o, we_o
    );

endinterface

// File: rtl/bp_me_wb_master.sv
// BedRock uncached command -> single-beat Wishbone B4 classic cycle -> BedRock
// response. One transaction in flight; every bus-facing control output is a
// decode of the state register, so there is no combinational input->output path.

// Protocol checker: flags commands the bridge cannot legally carry.
module bp_me_wb_master_chk
  #(parameter int data_width_p = 64)
  (input logic       clk_i
  ,input logic       reset_i
  ,input logic       fwd_fire_i
  ,input logic [3:0] msg_type_i
  ,input logic [2:0] size_i
  ,input logic [7:0] offset_i
  ,input logic       last_i
  );

  localparam logic [2:0] max_size_lp = 3'($clog2(data_width_p/8));

  uc_msg_only: assert property (@(posedge clk_i) disable iff (reset_i)
    fwd_fire_i |-> (msg_type_i == 4'b0010 || msg_type_i == 4'b0011));

  size_fits_bus: assert property (@(posedge clk_i) disable iff (reset_i)
    fwd_fire_i |-> (size_i <= max_size_lp));

  naturally_aligned: assert property (@(posedge clk_i) disable iff (reset_i)
    fwd_fire_i |-> ((offset_i & ((8'd1 << size_i) - 8'd1)) == 8'd0));

  single_beat: assert property (@(posedge clk_i) disable iff (reset_i)
    fwd_fire_i |-> last_i);

endmodule

module bp_me_wb_master
  #(parameter int paddr_width_p   = 40
   ,parameter int data_width_p    = 64
   ,parameter int payload_width_p = 16
   )
  (input logic               clk_i
  ,input logic               reset_i
  ,bp_me_wb_master_if.master bus
  );

  localparam int bytes_lp            = data_width_p / 8;
  localparam int byte_off_lp         = $clog2(bytes_lp);
  localparam int hdr_width_lp        = 4 + 3 + paddr_width_p + payload_width_p;
  localparam int wbone_addr_width_lp = paddr_width_p - byte_off_lp;
  localparam int size_lsb_lp         = 4;
  localparam int addr_lsb_lp         = 7;

  localparam logic [3:0] e_bedrock_mem_uc_wr = 4'b0011;

  typedef enum logic [1:0] {
    e_reset = 2'd0,
    e_ready = 2'd1,
    e_send  = 2'd2,
    e_resp  = 2'd3
  } state_e;

  state_e                  state_r, state_n;
  logic [hdr_width_lp-1:0] hdr_r;
  logic [data_width_p-1:0] wdata_r;
  logic [data_width_p-1:0] rdata_r;
  logic [bytes_lp-1:0]     sel_r;

  logic       fwd_fire_s;
  logic       ack_fire_s;
  logic       is_wr_s;
  logic [3:0] fwd_msg_s;
  logic [2:0] fwd_size_s;
  logic [7:0] fwd_off_s;
  logic [2:0] hdr_size_s;
  logic [7:0] hdr_off_s;

  // Byte offset of an address within one bus word.
  function automatic logic [7:0] byte_offset(input logic [7:0] addr_low);
    return addr_low & 8'(bytes_lp - 1);
  endfunction

  // Byte-lane mask: 2^size lanes starting at the byte offset.
  function automatic logic [bytes_lp-1:0] calc_sel(input logic [2:0] size,
                                                   input logic [7:0] off);
    logic [15:0] mask_v;
    logic [15:0] shifted_v;
    mask_v    = (16'd1 << (16'd1 << size)) - 16'd1;
    shifted_v = mask_v << off;
    return shifted_v[bytes_lp-1:0];
  endfunction

  // Move the addressed lanes down to lane 0 and replicate them across the bus.
  function automatic logic [data_width_p-1:0] calc_rdata(input logic [data_width_p-1:0] raw,
                                                         input logic [2:0]              size,
                                                         input logic [7:0]              off);
    logic [data_width_p-1:0] shifted_v;
    logic [data_width_p-1:0] result_v;
    int                      lane_mask_v;
    shifted_v   = raw >> {off, 3'b000};
    result_v    = '0;
    lane_mask_v = (1 << size) - 1;
    for (int i = 0; i < bytes_lp; i++) begin
      result_v[i*8 +: 8] = shifted_v[(i & lane_mask_v)*8 +: 8];
    end
    return result_v;
  endfunction

  assign fwd_msg_s  = bus.mem_fwd_header_i[3:0];
  assign fwd_size_s = bus.mem_fwd_header_i[size_lsb_lp +: 3];
  assign fwd_off_s  = byte_offset(bus.mem_fwd_header_i[addr_lsb_lp +: 8]);
  assign hdr_size_s = hdr_r[size_lsb_lp +: 3];
  assign hdr_off_s  = byte_offset(hdr_r[addr_lsb_lp +: 8]);
  assign is_wr_s    = (hdr_r[3:0] == e_bedrock_mem_uc_wr);

  assign fwd_fire_s = (state_r == e_ready) & bus.mem_fwd_v_i;
  assign ack_fire_s = (state_r == e_send) & bus.ack_i;

  // State register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= e_reset;
    end else begin
      state_r <= state_n;
    end
  end

  // Next-state logic: accept, run the WB cycle until ack, hold the response until taken.
  always_comb begin
    state_n = state_r;
    case (state_r)
      e_reset: state_n = e_ready;
      e_ready: begin
        if (fwd_fire_s) begin
          state_n = e_send;
        end else begin
          state_n = e_ready;
        end
      end
      e_send: begin
        if (bus.ack_i) begin
          state_n = e_resp;
        end else begin
          state_n = e_send;
        end
      end
      e_resp: begin
        if (bus.mem_rev_ready_and_i) begin
          state_n = e_ready;
        end else begin
          state_n = e_resp;
        end
      end
      default: state_n = e_reset;
    endcase
  end

  // Command capture on accept and response data capture on ack.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      hdr_r   <= '0;
      wdata_r <= '0;
      sel_r   <= '0;
      rdata_r <= '0;
    end else begin
      if (fwd_fire_s) begin
        hdr_r   <= bus.mem_fwd_header_i;
        wdata_r <= bus.mem_fwd_data_i;
        sel_r   <= calc_sel(fwd_size_s, fwd_off_s);
      end
      if (ack_fire_s) begin
        if (is_wr_s) begin
          rdata_r <= '0;
        end else begin
          rdata_r <= calc_rdata(bus.dat_i, hdr_size_s, hdr_off_s);
        end
      end
    end
  end

  assign bus.mem_fwd_ready_and_o = (state_r == e_ready);
  assign bus.cyc_o               = (state_r == e_send);
  assign bus.stb_o               = (state_r == e_send);
  assign bus.we_o                = (state_r == e_send) & is_wr_s;
  assign bus.adr_o               = hdr_r[addr_lsb_lp + byte_off_lp +: wbone_addr_width_lp];
  assign bus.dat_o               = wdata_r;
  assign bus.sel_o               = sel_r;
  assign bus.mem_rev_v_o         = (state_r == e_resp);
  assign bus.mem_rev_header_o    = hdr_r;
  assign bus.mem_rev_data_o      = rdata_r;
  assign bus.mem_rev_last_o      = 1'b1;

  bp_me_wb_master_chk #(.data_width_p(data_width_p)) chk
    (.clk_i      (clk_i)
    ,.reset_i    (reset_i)
    ,.fwd_fire_i (fwd_fire_s)
    ,.msg_type_i (fwd_msg_s)
    ,.size_i     (fwd_size_s)
    ,.offset_i   (fwd_off_s)
    ,.last_i     (bus.mem_fwd_last_i)
    );

endmodule

// File: tb/tb_bp_me_wb_master.sv
// Scoreboard bench for bp_me_wb_master: a byte-level memory model predicts every
// BedRock response and WB cycle; a WB slave and a response monitor check them.
module tb_bp_me_wb_master;

  localparam int paddr_lp = 40;
  localparam int dw_lp    = 64;
  localparam int pl_lp    = 16;
  localparam int hw_lp    = 4 + 3 + paddr_lp + pl_lp;
  localparam logic [3:0] uc_rd_lp = 4'b0010;
  localparam logic [3:0] uc_wr_lp = 4'b0011;

  logic clk = 1'b0;
  logic reset_i;
  always #5 clk = ~clk;

  bp_me_wb_master_if #(.paddr_width_p(paddr_lp), .data_width_p(dw_lp), .payload_width_p(pl_lp)) bus ();

  bp_me_wb_master #(.paddr_width_p(paddr_lp), .data_width_p(dw_lp), .payload_width_p(pl_lp)) dut
    (.clk_i(clk), .reset_i(reset_i), .bus(bus));

  typedef struct {
    logic [hw_lp-1:0] hdr;
    logic [dw_lp-1:0] data;
    int               lat;
  } rev_exp_t;

  typedef struct {
    logic [36:0] adr;
    logic [7:0]  sel;
    logic        we;
    logic [63:0] dat;
    int          wait_c;
  } wb_exp_t;

  rev_exp_t    sb_q[$];
  wb_exp_t     wb_q[$];
  logic [7:0]  ref_mem [logic [39:0]];
  logic [63:0] wb_mem  [logic [36:0]];

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int cyc_cnt  = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
  endtask

  function automatic logic [7:0] ref_rd(input logic [39:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
  endfunction

  task automatic preload(input logic [39:0] a, input logic [63:0] v);
    for (int b = 0; b < 8; b++) ref_mem[a + 40'(b)] = v[b*8 +: 8];
    wb_mem[a[39:3]] = v;
  endtask

  initial forever begin
    @(posedge clk);
    cyc_cnt++;
  end

  // Issue one command: predict its WB cycle and response, then drive it until accepted.
  task automatic issue(input logic [3:0] msg, input logic [2:0] size, input logic [39:0] addr,
                       input logic [63:0] data, input int wait_c, output int acc);
    rev_exp_t re;
    wb_exp_t  we;
    int       n;
    int       off;
    bit       got;
    n   = 1 << size;
    off = int'(addr[2:0]);
    re.hdr = {16'($urandom), addr, size, msg};
    re.lat = 2 + wait_c;
    we.adr = addr[39:3];
    we.sel = 8'h00;
    for (int b = 0; b < n; b++) we.sel[off + b] = 1'b1;
    we.we     = (msg == uc_wr_lp);
    we.dat    = data;
    we.wait_c = wait_c;
    re.data   = '0;
    if (msg == uc_wr_lp) begin
      for (int b = 0; b < n; b++) ref_mem[addr + 40'(b)] = data[(off + b)*8 +: 8];
    end else begin
      for (int i = 0; i < 8; i++) re.data[i*8 +: 8] = ref_rd(addr + 40'(i % n));
    end
    sb_q.push_back(re);
    wb_q.push_back(we);
    bus.mem_fwd_header_i = re.hdr;
    bus.mem_fwd_data_i   = data;
    bus.mem_fwd_v_i      = 1'b1;
    got = 1'b0;
    acc = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (bus.mem_fwd_ready_and_o) begin
        got = 1'b1;
        acc = cyc_cnt;
      end
    end
    if (!got) check("fwd_accept_timeout", 128'd0, 128'd1);
    @(posedge clk); #1;
    bus.mem_fwd_v_i = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (sb_q.size() != 0 && n < 200);
    check("drain", 128'(sb_q.size()), 128'd0);
  endtask

  // Reset release: one cycle in e_reset (not ready), then ready.
  task automatic release_reset();
    reset_i = 1'b0;
    check("ready_in_e_reset", 128'(bus.mem_fwd_ready_and_o), 128'd0);
    @(posedge clk); #1;
    check("ready_after_reset", 128'(bus.mem_fwd_ready_and_o), 128'd1);
  endtask

  // Wishbone slave: checks each cycle against the prediction and acks after wait_c cycles.
  initial begin
    bit      in_cyc   = 1'b0;
    bit      ack_prev = 1'b0;
    int      wcnt     = 0;
    wb_exp_t cur;
    logic [63:0] word;
    cur = '{adr: '0, sel: '0, we: 1'b0, dat: '0, wait_c: 0};
    bus.ack_i = 1'b0;
    bus.dat_i = '0;
    forever begin
      @(posedge clk); #1;
      if (ack_prev) check("cyc_drop_after_ack", 128'({bus.cyc_o, bus.stb_o}), 128'd0);
      bus.ack_i = 1'b0;
      ack_prev  = 1'b0;
      if (bus.cyc_o) begin
        if (!in_cyc) begin
          in_cyc = 1'b1;
          wcnt   = 0;
          if (wb_q.size() == 0) begin
            check("wb_unexpected_cycle", 128'd1, 128'd0);
          end else begin
            cur = wb_q.pop_front();
            check("wb_adr", 128'(bus.adr_o), 128'(cur.adr));
            check("wb_sel", 128'(bus.sel_o), 128'(cur.sel));
            check("wb_we",  128'(bus.we_o),  128'(cur.we));
            if (cur.we) check("wb_dat", 128'(bus.dat_o), 128'(cur.dat));
          end
        end else begin
          check("wb_hold", 128'({bus.adr_o, bus.sel_o, bus.we_o, bus.stb_o}),
                128'({cur.adr, cur.sel, cur.we, 1'b1}));
        end
        if (wcnt == cur.wait_c) begin
          word      = wb_mem.exists(bus.adr_o) ? wb_mem[bus.adr_o] : 64'd0;
          bus.dat_i = word;
          bus.ack_i = 1'b1;
          ack_prev  = 1'b1;
          if (bus.we_o) begin
            for (int l = 0; l < 8; l++)
              if (bus.sel_o[l]) word[l*8 +: 8] = bus.dat_o[l*8 +: 8];
            wb_mem[bus.adr_o] = word;
          end
        end
        wcnt++;
      end else begin
        in_cyc = 1'b0;
      end
    end
  end

  // Response monitor: pops the scoreboard on each presented response.
  initial begin
    bit               rev_seen = 1'b0;
    bit               have_exp = 1'b0;
    int               accept_cyc = 0;
    logic [hw_lp-1:0] cap_hdr;
    logic [dw_lp-1:0] cap_data;
    rev_exp_t         e;
    forever begin
      @(negedge clk);
      if (reset_i) begin
        rev_seen = 1'b0;
      end else begin
        if (bus.mem_fwd_v_i && bus.mem_fwd_ready_and_o) accept_cyc = cyc_cnt;
        if (bus.mem_rev_v_o) begin
          if (!rev_seen) begin
            rev_seen = 1'b1;
            cap_hdr  = bus.mem_rev_header_o;
            cap_data = bus.mem_rev_data_o;
            have_exp = (sb_q.size() != 0);
            if (!have_exp) begin
              check("rev_unexpected", 128'd1, 128'd0);
            end else begin
              e = sb_q[0];
              check("rev_latency", 128'(cyc_cnt - accept_cyc), 128'(e.lat));
              check("rev_header",  128'(bus.mem_rev_header_o), 128'(e.hdr));
              check("rev_data",    128'(bus.mem_rev_data_o),   128'(e.data));
              check("rev_last",    128'(bus.mem_rev_last_o),   128'd1);
            end
          end else begin
            check("rev_hold_header", 128'(bus.mem_rev_header_o), 128'(cap_hdr));
            check("rev_hold_data",   128'(bus.mem_rev_data_o),   128'(cap_data));
            check("rev_hold_idle",   128'({bus.mem_fwd_ready_and_o, bus.cyc_o}), 128'd0);
          end
          if (bus.mem_rev_ready_and_i) begin
            if (have_exp) void'(sb_q.pop_front());
            rev_seen = 1'b0;
          end
        end
      end
    end
  end

  // Stimulus.
  initial begin
    int acc;
    int prev_acc;
    reset_i                 = 1'b1;
    bus.mem_fwd_header_i    = '0;
    bus.mem_fwd_data_i      = '0;
    bus.mem_fwd_v_i         = 1'b0;
    bus.mem_fwd_last_i      = 1'b1;
    bus.mem_rev_ready_and_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ctl", 128'({bus.cyc_o, bus.stb_o, bus.we_o, bus.mem_fwd_ready_and_o, bus.mem_rev_v_o}), 128'd0);
    check("reset_sel", 128'(bus.sel_o), 128'd0);
    check("reset_rev_header", 128'(bus.mem_rev_header_o), 128'd0);
    check("reset_rev_data", 128'(bus.mem_rev_data_o), 128'd0);
    release_reset();

    // Full-width write, zero-wait ack.
    issue(uc_wr_lp, 3'd3, 40'h00_8000_0010, 64'h1122334455667788, 0, acc);
    wait_idle();

    // Byte read at offset 5.
    preload(40'h00_8000_0020, 64'h8877665544332211);
    issue(uc_rd_lp, 3'd0, 40'h00_8000_0025, 64'd0, 0, acc);
    wait_idle();

    // Halfword read at offset 2 with 7 wait cycles.
    issue(uc_rd_lp, 3'd1, 40'h00_8000_0022, 64'd0, 7, acc);
    wait_idle();

    // Response back-pressure while another command is offered.
    bus.mem_rev_ready_and_i = 1'b0;
    issue(uc_rd_lp, 3'd2, 40'h00_8000_0024, 64'd0, 0, acc);
    @(posedge clk); #1;
    bus.mem_fwd_header_i = {16'h0, 40'h00_8000_0000, 3'd3, uc_rd_lp};
    bus.mem_fwd_v_i      = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
    end
    bus.mem_fwd_v_i         = 1'b0;
    bus.mem_rev_ready_and_i = 1'b1;
    wait_idle();

    // Reset in the middle of a WB cycle.
    issue(uc_rd_lp, 3'd3, 40'h00_8000_0040, 64'd0, 30, acc);
    check("cyc_before_reset", 128'(bus.cyc_o), 128'd1);
    @(posedge clk); #1;
    reset_i = 1'b1;
    @(posedge clk); #1;
    check("reset_drops_cycle", 128'({bus.cyc_o, bus.stb_o, bus.mem_rev_v_o, bus.mem_fwd_ready_and_o}), 128'd0);
    sb_q.delete();
    wb_q.delete();
    @(posedge clk); #1;
    release_reset();
    repeat (3) begin
      @(posedge clk); #1;
    end
    issue(uc_wr_lp, 3'd2, 40'h00_8000_0048, 64'hCAFEBABECAFEBABE, 1, acc);
    wait_idle();
    issue(uc_rd_lp, 3'd3, 40'h00_8000_0048, 64'd0, 0, acc);
    wait_idle();

    // Back-to-back random traffic, zero-wait ack.
    prev_acc = 0;
    for (int t = 0; t < 10; t++) begin
      logic [2:0]  sz;
      int          n;
      logic [39:0] a;
      logic [63:0] v;
      logic [63:0] d;
      sz = 3'($urandom_range(0, 3));
      n  = 1 << sz;
      a  = 40'h00_8000_0000 + 40'($urandom_range(0, 3) * 8) + 40'($urandom_range(0, 8/n - 1) * n);
      v  = {$urandom, $urandom};
      for (int i = 0; i < 8; i++) d[i*8 +: 8] = v[(i % n)*8 +: 8];
      issue(($urandom_range(0, 1) == 0) ? uc_rd_lp : uc_wr_lp, sz, a, d, 0, acc);
      if (t > 0) check("b2b_spacing", 128'(acc - prev_acc), 128'd3);
      prev_acc = acc;
    end
    wait_idle();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
